// File: rtl/lsu_subword_bridge_if.sv
// Request/response/memory bundle for lsu_subword_bridge.
// slave = the bridge itself, master = core plus data memory side.
interface lsu_subword_bridge_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_subword_bridge.sv
// Byte/half/word load-store bridge onto a word-only memory; sub-word stores are read-modify-write.
// Define LSU_ALIGN_CHECK_EN to flag misaligned/unsupported accesses via rsp_err.
module lsu_subword_bridge #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic               CLK,
    input  logic               RST,
    lsu_subword_bridge_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Anything not a recognised sub-word encoding is handled as a full word.
    function automatic logic [1:0] size_of(input logic we, input logic [2:0] f3);
        logic [1:0] sz;
        if (we && f3[2]) sz = SZ_W;
        else begin
            case (f3[1:0])
                2'b00:   sz = SZ_B;
                2'b01:   sz = SZ_H;
                default: sz = SZ_W;
            endcase
        end
        return sz;
    endfunction

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           word_q, word_d;
    logic                  err_q, err_d;

    logic                  req_ready_c;
    logic                  req_err;
    logic [1:0]            sz;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [31:0]           ld_data;
    logic [31:0]           st_word;

`ifdef LSU_ALIGN_CHECK_EN
    logic [1:0] req_sz;
    logic       req_unsup;
    always_comb begin
        req_sz = size_of(bus.req_we, bus.req_funct3);
        if (bus.req_we) req_unsup = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
        else            req_unsup = bus.req_funct3 inside {3'b011, 3'b110, 3'b111};
        req_err = req_unsup ||
                  (req_sz == SZ_H && bus.req_addr[0]) ||
                  (req_sz == SZ_W && bus.req_addr[1:0] != 2'b00);
    end
`else
    assign req_err = 1'b0;
`endif

    assign sz = size_of(we_q, funct3_q);

    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = word_q[7:0];
            2'd1:    ld_byte = word_q[15:8];
            2'd2:    ld_byte = word_q[23:16];
            default: ld_byte = word_q[31:24];
        endcase
        ld_half = addr_q[1] ? word_q[31:16] : word_q[15:0];
        case (sz)
            SZ_B:    ld_data = funct3_q[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = funct3_q[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = word_q;
        endcase
    end

    always_comb begin
        st_word = word_q;
        case (sz)
            SZ_B: begin
                case (addr_q[1:0])
                    2'd0:    st_word[7:0]   = wdata_q[7:0];
                    2'd1:    st_word[15:8]  = wdata_q[7:0];
                    2'd2:    st_word[23:16] = wdata_q[7:0];
                    default: st_word[31:24] = wdata_q[7:0];
                endcase
            end
            SZ_H: begin
                if (addr_q[1]) st_word[31:16] = wdata_q[15:0];
                else           st_word[15:0]  = wdata_q[15:0];
            end
            default: st_word = wdata_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        funct3_d      = funct3_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        word_d        = word_q;
        err_d         = err_q;
        req_ready_c   = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 32'd0;
        bus.rsp_err   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = 32'd0;
        case (state_q)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    err_d    = req_err;
                    if (req_err)
                        state_d = RESP;
                    else if (bus.req_we && size_of(bus.req_we, bus.req_funct3) == SZ_W)
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                word_d  = bus.mem_rdata;
                state_d = we_q ? WR : RESP;
            end
            WR: begin
                bus.mem_we    = 1'b1;
                bus.mem_wdata = st_word;
                state_d       = RESP;
            end
            default: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err_q;
                bus.rsp_rdata = (we_q || err_q) ? 32'd0 : ld_data;
                state_d       = IDLE;
            end
        endcase
    end

    // Combinational state is IDLE during reset, so gate ready explicitly.
    assign bus.req_ready = req_ready_c && !RST;
    assign bus.mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            word_q   <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_lsu_subword_bridge.sv
// Directed bench for lsu_subword_bridge with a small word memory model.
module tb_lsu_subword_bridge;
`ifdef LSU_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    lsu_subword_bridge_if #(.ADDR_WIDTH(32)) bus ();
    lsu_subword_bridge #(.ADDR_WIDTH(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    logic [31:0] mem [16];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [31:0] pre_val = 32'd0;

    assign bus.mem_rdata = mem[bus.mem_addr[5:2]];
    always @(posedge CLK) begin
        if (pre_we)          mem[pre_idx] <= pre_val;
        else if (bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        @(negedge CLK);
        pre_we = 1'b1; pre_idx = idx; pre_val = val;
        @(negedge CLK);
        pre_we = 1'b0;
    endtask

    // exp_we = cycle after accept in which the single write is expected, 0 = none
    task automatic run(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_we, input logic [31:0] exp_wd);
        int lat = 0, we_cyc = 0, we_cnt = 0;
        logic [31:0] rd = 32'hx, wv = 32'hx;
        logic er = 1'bx;
        @(negedge CLK);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wd;
        chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        @(posedge CLK);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (bus.mem_we) begin we_cnt++; we_cyc = k; wv = bus.mem_wdata; end
            if (bus.rsp_valid) begin lat = k; rd = bus.rsp_rdata; er = bus.rsp_err; break; end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        chk({tag, "_wecnt"}, we_cnt, (exp_we != 0) ? 1 : 0);
        if (exp_we != 0) begin
            chk({tag, "_wecyc"}, we_cyc, exp_we);
            chk({tag, "_wdata"}, wv, exp_wd);
        end
        @(negedge CLK);
        chk({tag, "_pulse"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        int bad_we, bad_rsp;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        for (int i = 0; i < 16; i++) preload(i[3:0], 32'h0);
        preload(4'd1, 32'h11223344);
        preload(4'd2, 32'h8899AABB);
        @(negedge CLK);
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_rspv",  {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_memwe", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_maddr", bus.mem_addr, 32'd0);
        chk("rst_mwd",   bus.mem_wdata, 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        RST = 1'b0;
        #1 chk("rel_ready", {31'd0, bus.req_ready}, 32'd1);

        run("lb9",   0, 3'b000, 32'h9, 0, 2, 32'hFFFFFFAA, 0, 0, 0);
        run("lbuB",  0, 3'b100, 32'hB, 0, 2, 32'h00000088, 0, 0, 0);
        run("lhA",   0, 3'b001, 32'hA, 0, 2, 32'hFFFF8899, 0, 0, 0);
        run("lhu8",  0, 3'b101, 32'h8, 0, 2, 32'h0000AABB, 0, 0, 0);
        run("lw8",   0, 3'b010, 32'h8, 0, 2, 32'h8899AABB, 0, 0, 0);
        run("sbA",   1, 3'b000, 32'hA, 32'h12345677, 3, 32'h0, 0, 2, 32'h8877AABB);
        run("lw8b",  0, 3'b010, 32'h8, 0, 2, 32'h8877AABB, 0, 0, 0);
        preload(4'd2, 32'h8899AABB);
        run("sh8",   1, 3'b001, 32'h8, 32'h0000CAFE, 3, 32'h0, 0, 2, 32'h8899CAFE);
        run("sw8",   1, 3'b010, 32'h8, 32'hDEADBEEF, 2, 32'h0, 0, 1, 32'hDEADBEEF);
        run("lw8c",  0, 3'b010, 32'h8, 0, 2, 32'hDEADBEEF, 0, 0, 0);
        run("lw6",   0, 3'b010, 32'h6, 0, ALIGN ? 1 : 2,
            ALIGN ? 32'h0 : 32'h11223344, ALIGN, 0, 0);
        run("lh9",   0, 3'b001, 32'h9, 0, ALIGN ? 1 : 2,
            ALIGN ? 32'h0 : 32'hFFFFBEEF, ALIGN, 0, 0);
        run("ld011", 0, 3'b011, 32'h8, 0, ALIGN ? 1 : 2,
            ALIGN ? 32'h0 : 32'hDEADBEEF, ALIGN, 0, 0);

        // Reset arriving while a sub-word store sits in RD
        @(negedge CLK);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'hA; bus.req_wdata = 32'h55;
        @(posedge CLK);
        #1 bus.req_valid = 1'b0;
        @(negedge CLK);
        chk("mid_rd_we", {31'd0, bus.mem_we}, 32'd0);
        RST = 1'b1;
        #1;
        chk("mid_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("mid_maddr", bus.mem_addr, 32'd0);
        bad_we = 0; bad_rsp = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (bus.mem_we) bad_we++;
            if (bus.rsp_valid) bad_rsp++;
        end
        RST = 1'b0;
        #1 chk("mid_rel_ready", {31'd0, bus.req_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (bus.mem_we) bad_we++;
            if (bus.rsp_valid) bad_rsp++;
        end
        chk("mid_we_cnt", bad_we, 0);
        chk("mid_rsp_cnt", bad_rsp, 0);
        run("lw_after", 0, 3'b010, 32'h8, 0, 2, 32'hDEADBEEF, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
